// File: rtl/unit_writeback_arb.sv
// Write-back arbiter: collects single-strobe results from six neuron units and
// serialises them, round-robin, into the RAM write port with per-unit acks.
module unit_writeback_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] result0,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    input  logic [DATA_W-1:0] result3,
    input  logic [DATA_W-1:0] result4,
    input  logic [DATA_W-1:0] result5,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              valid2,
    input  logic              valid3,
    input  logic              valid4,
    input  logic              valid5,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    output logic              ack3,
    output logic              ack4,
    output logic              ack5,
    output logic              layer_done,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        dbg_ptr_o
);

    localparam int N = 6;

    logic [DATA_W-1:0] result_w [N];
    logic [N-1:0]      valid_w;

    logic [DATA_W-1:0] hold_q [N];
    logic [DATA_W-1:0] hold_d [N];
    logic [N-1:0]      pending_q, pending_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [N-1:0]      done_q, done_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              ld_q, ld_d;
    logic              ovr_q, ovr_d;

    logic              gnt_found;
    logic [2:0]        gnt_idx;
    logic [N-1:0]      gnt_onehot;
    logic [N-1:0]      done_mask;

    assign result_w[0] = result0;
    assign result_w[1] = result1;
    assign result_w[2] = result2;
    assign result_w[3] = result3;
    assign result_w[4] = result4;
    assign result_w[5] = result5;
    assign valid_w     = {valid5, valid4, valid3, valid2, valid1, valid0};

    // Scan ptr, ptr+1, ... (mod 6); iterating downward lets the nearest hit win.
    function automatic logic [3:0] pick_grant(input logic [N-1:0] pend, input logic [2:0] ptr);
        logic [3:0] res;
        logic [3:0] sum;
        res = 4'b0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'd6) begin
                sum = sum - 4'd6;
            end
            if (pend[sum[2:0]]) begin
                res = {1'b1, sum[2:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        logic [3:0] pick;
        pick       = pick_grant(pending_q, ptr_q);
        gnt_found  = pick[3];
        gnt_idx    = pick[2:0];
        gnt_onehot = gnt_found ? (6'b000001 << gnt_idx) : 6'b000000;
        done_mask  = done_q | gnt_onehot;
    end

    always_comb begin
        hold_d    = hold_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        done_d    = done_q;
        we_d      = 1'b0;
        data_d    = data_q;
        addr_d    = addr_q;
        ack_d     = '0;
        ld_d      = 1'b0;
        ovr_d     = ovr_q;

        if (gnt_found) begin
            we_d   = 1'b1;
            data_d = hold_q[gnt_idx];
            addr_d = base_addr + ADDR_W'(gnt_idx);
            ack_d  = gnt_onehot;
            ptr_d  = (gnt_idx == 3'd5) ? 3'd0 : gnt_idx + 3'd1;
            if (&done_mask) begin
                ld_d   = 1'b1;
                done_d = '0;
            end else begin
                done_d = done_mask;
            end
        end

        // A unit granted this edge is free again, so its new strobe refills it.
        for (int i = 0; i < N; i++) begin
            pending_d[i] = pending_q[i] & ~gnt_onehot[i];
            if (valid_w[i]) begin
                if (!pending_d[i]) begin
                    hold_d[i]    = result_w[i];
                    pending_d[i] = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                hold_q[i] <= '0;
            end
            pending_q <= '0;
            ptr_q     <= '0;
            done_q    <= '0;
            we_q      <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            ack_q     <= '0;
            ld_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            done_q    <= done_d;
            we_q      <= we_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            ack_q     <= ack_d;
            ld_q      <= ld_d;
            ovr_q     <= ovr_d;
        end
    end

    assign ram_in     = data_q;
    assign ram_addr   = addr_q;
    assign ram_we     = we_q;
    assign ack0       = ack_q[0];
    assign ack1       = ack_q[1];
    assign ack2       = ack_q[2];
    assign ack3       = ack_q[3];
    assign ack4       = ack_q[4];
    assign ack5       = ack_q[5];
    assign layer_done = ld_q;
    assign busy       = |pending_q;
    assign overrun    = ovr_q;
    assign dbg_ptr_o  = ptr_q;

endmodule

// File: tb/tb_unit_writeback_arb.sv
// Randomised and directed bench for unit_writeback_arb: a queue-based reference
// model predicts every edge's outputs; a monitor compares them after each edge.
module tb_unit_writeback_arb;

    logic        CLOCK;
    logic        RESET;
    logic [31:0] drv_res [6];
    logic [5:0]  drv_v;
    logic [7:0]  base_addr;
    logic [31:0] ram_in;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [5:0]  ack_w;
    logic        layer_done, busy, overrun;
    logic [2:0]  dbg_ptr;

    logic [31:0] stg_res [6];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        we;
        logic [5:0]  ack;
        logic        ld;
        logic [31:0] data;
        logic [7:0]  addr;
        logic        busy;
        logic        ovr;
        logic [2:0]  ptr;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit          m_pend [6];
    logic [31:0] m_hold [6];
    bit          m_done [6];
    int          m_ptr;
    bit          m_ovr;
    logic [31:0] m_data;
    logic [7:0]  m_addr;

    unit_writeback_arb #(.DATA_W(32), .ADDR_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .result0(drv_res[0]), .result1(drv_res[1]), .result2(drv_res[2]),
        .result3(drv_res[3]), .result4(drv_res[4]), .result5(drv_res[5]),
        .valid0(drv_v[0]), .valid1(drv_v[1]), .valid2(drv_v[2]),
        .valid3(drv_v[3]), .valid4(drv_v[4]), .valid5(drv_v[5]),
        .base_addr(base_addr),
        .ram_in(ram_in), .ram_addr(ram_addr), .ram_we(ram_we),
        .ack0(ack_w[0]), .ack1(ack_w[1]), .ack2(ack_w[2]),
        .ack3(ack_w[3]), .ack4(ack_w[4]), .ack5(ack_w[5]),
        .layer_done(layer_done), .busy(busy), .overrun(overrun),
        .dbg_ptr_o(dbg_ptr)
    );

    // Clock / reset
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        RESET     = 1'b1;
        drv_v     = '0;
        base_addr = '0;
        for (int i = 0; i < 6; i++) begin
            drv_res[i] = '0;
            stg_res[i] = '0;
        end
    end

    function automatic exp_t model_step(input logic [5:0] vm, input logic [7:0] base, input bit rst);
        exp_t e;
        int   g;
        bit   all_done;
        e = '0;
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_pend[i] = 0;
                m_hold[i] = '0;
                m_done[i] = 0;
            end
            m_ptr  = 0;
            m_ovr  = 0;
            m_data = '0;
            m_addr = '0;
            return e;
        end
        g = -1;
        for (int k = 0; k < 6; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % 6]) g = (m_ptr + k) % 6;
        end
        if (g >= 0) begin
            e.we      = 1'b1;
            e.ack[g]  = 1'b1;
            m_data    = m_hold[g];
            m_addr    = 8'((int'(base) + g) % 256);
            m_pend[g] = 0;
            m_ptr     = (g + 1) % 6;
            m_done[g] = 1;
            all_done  = 1;
            for (int i = 0; i < 6; i++) if (!m_done[i]) all_done = 0;
            if (all_done) begin
                e.ld = 1'b1;
                for (int i = 0; i < 6; i++) m_done[i] = 0;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (vm[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1;
                    m_hold[i] = stg_res[i];
                end else begin
                    m_ovr = 1;
                end
            end
        end
        e.data = m_data;
        e.addr = m_addr;
        e.ovr  = m_ovr;
        e.ptr  = 3'(m_ptr);
        e.busy = 1'b0;
        for (int i = 0; i < 6; i++) if (m_pend[i]) e.busy = 1'b1;
        return e;
    endfunction

    // Driver: one call = one clock edge of stimulus.
    task automatic drive(input logic [5:0] vm, input logic [7:0] base, input bit rst);
        @(negedge CLOCK);
        RESET     = rst;
        drv_v     = vm;
        base_addr = base;
        for (int i = 0; i < 6; i++) drv_res[i] = stg_res[i];
        exp_q.push_back(model_step(vm, base, rst));
    endtask

    task automatic idle(input int n, input logic [7:0] base);
        for (int c = 0; c < n; c++) drive(6'b0, base, 1'b0);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ram_we", 32'(ram_we), 32'(e.we));
                chk("ack", 32'(ack_w), 32'(e.ack));
                chk("layer_done", 32'(layer_done), 32'(e.ld));
                chk("ram_in", ram_in, e.data);
                chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("overrun", 32'(overrun), 32'(e.ovr));
                chk("ptr", 32'(dbg_ptr), 32'(e.ptr));
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [7:0] base;
        int         dens;
        #1;
        // single unit
        drive(6'b0, 8'h40, 1'b1);
        stg_res[3] = 32'hDEADBEEF;
        drive(6'b001000, 8'h40, 1'b0);
        idle(4, 8'h40);

        // all six in one cycle
        drive(6'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) stg_res[i] = 32'h10 + 32'(i);
        drive(6'b111111, 8'h00, 1'b0);
        idle(8, 8'h00);

        // fairness: grant 4, then 1 and 5 pending -> 5 then 1, ptr ends at 2
        drive(6'b0, 8'h20, 1'b1);
        stg_res[4] = 32'hA4;
        drive(6'b010000, 8'h20, 1'b0);
        stg_res[1] = 32'hB1;
        stg_res[5] = 32'hB5;
        drive(6'b100010, 8'h20, 1'b0);
        idle(4, 8'h20);

        // address wrap
        drive(6'b0, 8'hFE, 1'b1);
        stg_res[3] = 32'h0000_3333;
        drive(6'b001000, 8'hFE, 1'b0);
        idle(3, 8'hFE);

        // overrun: 0 and 1 pending, re-strobe 1 while 0 is granted
        drive(6'b0, 8'h00, 1'b1);
        stg_res[0] = 32'hC0;
        stg_res[1] = 32'hC1;
        drive(6'b000011, 8'h00, 1'b0);
        stg_res[1] = 32'hBAD1;
        drive(6'b000010, 8'h00, 1'b0);
        idle(4, 8'h00);

        // refill on grant edge
        drive(6'b0, 8'h00, 1'b1);
        stg_res[0] = 32'hD0;
        drive(6'b000001, 8'h00, 1'b0);
        stg_res[0] = 32'hD1;
        drive(6'b000001, 8'h00, 1'b0);
        idle(4, 8'h00);

        // reset mid-operation
        drive(6'b0, 8'h50, 1'b1);
        for (int i = 0; i < 6; i++) stg_res[i] = 32'hE0 + 32'(i);
        drive(6'b001111, 8'h50, 1'b0);
        drive(6'b0, 8'h50, 1'b1);
        idle(3, 8'h50);
        stg_res[2] = 32'hF2;
        drive(6'b000100, 8'h50, 1'b0);
        idle(3, 8'h50);

        // randomised traffic at varying densities
        base = 8'($urandom_range(0, 255));
        for (int seg = 0; seg < 12; seg++) begin
            dens = (seg % 4 == 0) ? 10 : (seg % 4 == 1) ? 30 : (seg % 4 == 2) ? 60 : 90;
            for (int c = 0; c < 250; c++) begin
                logic [5:0] vm;
                for (int i = 0; i < 6; i++) begin
                    stg_res[i] = $urandom;
                    vm[i]      = ($urandom_range(0, 99) < dens);
                end
                if ($urandom_range(0, 19) == 0) base = 8'($urandom_range(0, 255));
                drive(vm, base, ($urandom_range(0, 299) == 0));
            end
        end
        idle(10, base);

        @(posedge CLOCK);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unit_writeback_arb.md
# unit_writeback_arb

Collects 32-bit results from the six neuron units and serialises them into the weight/activation RAM write port, one write per clock. It is the write-back counterpart of the RAM-to-unit weight distribution mux. Each unit hands over a result with a single-cycle `valid` strobe and gets a single-cycle `ack` when its word is written. A round-robin arbiter, per-unit holding registers and a layer-completion tracker sit between the units and the RAM.

## Interface
Parameters
- DATA_W, 32, result and RAM data width
- ADDR_W, 8, RAM address width

Ports
- CLOCK  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- result0..result5  in  DATA_W  result word from unit i
- valid0..valid5  in  1  unit i presents `result_i` this cycle
- base_addr  in  ADDR_W  RAM base address of current layer's output block; sampled at each grant
- ram_in  out  DATA_W  write data to RAM (reg)
- ram_addr  out  ADDR_W  write address to RAM (reg)
- ram_we  out  1  RAM write enable (reg)
- ack0..ack5  out  1  one-cycle pulse: unit i's held word written this cycle (reg)
- layer_done  out  1  one-cycle pulse coincident with the write completing all six units (reg)
- busy  out  1  any holding register pending (combinational OR of pending flags)
- overrun  out  1  sticky: a valid arrived for a unit already pending and not granted that edge (reg)

## Operation
- Per unit i: `hold_i` (DATA_W) and `pending_i` (1).
- Capture at a rising edge when `valid_i`=1 and `pending_i`=0: `hold_i` <= `result_i` and `pending_i` <= 1.
- `valid_i`=1 with `pending_i`=1:
  - If unit i is granted at that same edge, the new word is captured and `pending_i` stays 1. Free-and-refill is legal.
  - Otherwise the word is dropped and `overrun` <= 1. `overrun` clears only on RESET.
- Arbiter, evaluated every edge using the pending flags as they stand before the edge:
  - Grant g = first pending unit searched in order ptr, ptr+1, ..., wrapping mod 6.
  - If a grant exists:
    - ram_we <= 1
    - ram_in <= hold_g
    - ram_addr <= base_addr + g, truncated to ADDR_W (wraps mod 2^ADDR_W)
    - ack_g <= 1, all other acks <= 0
    - pending_g <= 0, unless refilled at the same edge
    - ptr <= (g+1) mod 6
  - If no unit is pending: ram_we <= 0, all acks <= 0, ptr unchanged. ram_in and ram_addr hold their last values.
- Completion tracker `done_mask[5:0]`:
  - Bit g is set on each grant.
  - When the grant makes the mask all ones, layer_done <= 1 for one cycle and the mask clears at that same edge.
  - A repeat write for an already-set bit does not advance completion.
- RESET while active clears all of the following at that edge, and pending words are discarded without ack:
  - pending flags, hold registers
  - ptr = 0, done_mask = 0
  - ram_we, ram_in, ram_addr, every ack, layer_done and overrun = 0

## Timing
- Reset values: every registered output is 0; busy is 0.
- Minimum latency:
  - valid sampled at edge E0, pending visible after E0.
  - Earliest grant is at E1; ram_we/ram_in/ram_addr/ack are valid in the cycle after E1.
  - Result: 2 edges from valid to RAM write.
- Throughput: one RAM write per cycle. With all six pending, all six are written in 6 consecutive cycles in order ptr..ptr+5.
- ack_i and ram_we for that word are asserted in the same cycle. A unit may re-strobe valid in its ack cycle, and that word is accepted.
- Worst-case wait from a unit's capture to its grant: 6 edges (fairness bound).
- layer_done is asserted in the same cycle as the sixth distinct ram_we.

## Test plan
- Single unit: RESET, then valid3=1 with result3=0xDEADBEEF, base_addr=0x40 → two edges later ram_we=1, ram_addr=0x43, ram_in=0xDEADBEEF, ack3=1 for exactly one cycle; busy=0 afterward; layer_done stays 0.
- All six strobed in the same cycle, results 0x10..0x15, base_addr=0x00, ptr=0 → writes on six consecutive cycles to addresses 0..5 with matching data; ack0..ack5 in sequence; layer_done=1 only on the address-5 write.
- Round-robin fairness: after a grant to unit 4, units 1 and 5 are pending → unit 5 is written first, then unit 1; ptr ends at 2.
- Address wrap: base_addr=0xFE, unit 3 written → ram_addr=0x01.
- Overrun and refill:
  - With units 0 and 1 pending and ptr=0, re-strobe valid1 → overrun=1 and unit 1's original word is written.
  - In a separate run, re-strobe valid0 on its grant edge → new word is captured and written next, overrun remains 0.
- Reset mid-operation: four units pending, assert RESET for one cycle → no ram_we or acks follow, all outputs 0, and a fresh valid2 afterwards writes to base_addr+2 with ptr starting at 0.
